// File: rtl/scv_video_sig.sv
// scv_video_sig: per-line and per-frame CRC-16 video signature engine with one-shot/continuous capture
// Ports:
//   CLK, RESB             clock, asynchronous active-low reset
//   CE, DE, VS, PIX       pixel enable, display enable, vertical sync, pixel data (sampled on CE)
//   ARM, CONT             start capture pulse, continuous capture select
//   BUSY                  capture armed or running
//   LINE_VALID/CRC/LEN    last completed line signature
//   FRAME_VALID/CRC/LINES last completed frame signature
//   LEN_ERR               sticky line length mismatch within a frame
module scv_video_sig #(
  parameter int PW = 24,
  parameter int LW = 10,
  parameter int FW = 9,
  parameter logic [15:0] POLY = 16'h1021
) (
  input  logic          CLK,
  input  logic          RESB,
  input  logic          CE,
  input  logic          DE,
  input  logic          VS,
  input  logic [PW-1:0] PIX,
  input  logic          ARM,
  input  logic          CONT,
  output logic          BUSY,
  output logic          LINE_VALID,
  output logic [15:0]   LINE_CRC,
  output logic [LW-1:0] LINE_LEN,
  output logic          FRAME_VALID,
  output logic [15:0]   FRAME_CRC,
  output logic [FW-1:0] FRAME_LINES,
  output logic          LEN_ERR
);
  typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, DONE} state_t;
  state_t state;
  logic vs_q, de_q, ref_ok;
  logic [15:0] line_crc, frame_crc;
  logic [LW-1:0] pix_cnt, ref_len, pix_next;
  logic [FW-1:0] line_cnt, lines_next;
  logic cap, vs_rise, pix_on, line_close, frame_start;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [PW-1:0] d);
    logic [15:0] r;
    r = c;
    for (int i = PW - 1; i >= 0; i--) r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? POLY : 16'h0000);
    return r;
  endfunction

  assign cap = state == CAPTURE;
  assign BUSY = state == WAIT_VS || cap;
  assign vs_rise = CE & VS & ~vs_q;
  assign pix_on = cap & CE & DE;
  // An open line is closed by the falling DE edge or, if DE is still high, by the frame boundary
  assign line_close = cap & CE & de_q & (~DE | vs_rise);
  assign frame_start = (state == WAIT_VS || cap) & vs_rise;
  assign pix_next = &pix_cnt ? pix_cnt : pix_cnt + LW'(1);
  assign lines_next = &line_cnt ? line_cnt : line_cnt + FW'(1);

  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      state <= IDLE;
      vs_q <= 1'b0;
      de_q <= 1'b0;
      ref_ok <= 1'b0;
      ref_len <= '0;
      line_crc <= 16'hFFFF;
      frame_crc <= 16'hFFFF;
      pix_cnt <= '0;
      line_cnt <= '0;
      LINE_VALID <= 1'b0;
      LINE_CRC <= '0;
      LINE_LEN <= '0;
      FRAME_VALID <= 1'b0;
      FRAME_CRC <= '0;
      FRAME_LINES <= '0;
      LEN_ERR <= 1'b0;
    end else begin
      LINE_VALID <= 1'b0;
      FRAME_VALID <= 1'b0;
      if (CE) begin
        vs_q <= VS;
        de_q <= DE;
      end
      if ((state == IDLE || state == DONE) && ARM) begin
        state <= WAIT_VS;
        LEN_ERR <= 1'b0;
      end
      if (line_close) begin
        LINE_CRC <= line_crc;
        LINE_LEN <= pix_cnt;
        LINE_VALID <= 1'b1;
        line_cnt <= lines_next;
        line_crc <= 16'hFFFF;
        pix_cnt <= '0;
        if (!ref_ok) begin
          ref_len <= pix_cnt;
          ref_ok <= 1'b1;
        end else if (pix_cnt != ref_len) LEN_ERR <= 1'b1;
      end
      if (pix_on) begin
        line_crc <= crc_step(line_crc, PIX);
        frame_crc <= crc_step(frame_crc, PIX);
        pix_cnt <= pix_next;
      end
      if (cap && vs_rise) begin
        FRAME_CRC <= frame_crc;
        FRAME_LINES <= line_close ? lines_next : line_cnt;
        FRAME_VALID <= 1'b1;
      end
      // A pixel on the boundary CE cycle already belongs to the new frame
      if (frame_start) begin
        state <= (cap && !CONT) ? DONE : CAPTURE;
        line_cnt <= '0;
        ref_ok <= 1'b0;
        ref_len <= '0;
        line_crc <= DE ? crc_step(16'hFFFF, PIX) : 16'hFFFF;
        frame_crc <= DE ? crc_step(16'hFFFF, PIX) : 16'hFFFF;
        pix_cnt <= DE ? LW'(1) : '0;
      end
    end
  end
endmodule

// File: tb/tb_scv_video_sig.sv
// tb_scv_video_sig: scoreboard bench for scv_video_sig with PW=8 and a saturating LW=4 companion
module tb_scv_video_sig;
  logic clk = 1'b0;
  logic resb, ce, de, vs, arm, cont;
  logic [7:0] pix;
  logic busy, line_valid, frame_valid, len_err;
  logic [15:0] line_crc, frame_crc;
  logic [9:0] line_len;
  logic [8:0] frame_lines;
  logic d2_busy, d2_lv, d2_fv, d2_err;
  logic [15:0] d2_lcrc, d2_fcrc;
  logic [3:0] d2_len;
  logic [8:0] d2_lines;
  int checks = 0, errors = 0, lv_n = 0, fv_n = 0, both_n = 0;
  typedef struct packed {logic [15:0] crc; logic [9:0] len; logic err;} line_t;
  typedef struct packed {logic [15:0] crc; logic [8:0] lines; logic err;} frame_t;
  line_t line_q[$];
  frame_t frame_q[$];

  scv_video_sig #(.PW(8), .LW(10), .FW(9)) dut (
    .CLK(clk), .RESB(resb), .CE(ce), .DE(de), .VS(vs), .PIX(pix), .ARM(arm), .CONT(cont),
    .BUSY(busy), .LINE_VALID(line_valid), .LINE_CRC(line_crc), .LINE_LEN(line_len),
    .FRAME_VALID(frame_valid), .FRAME_CRC(frame_crc), .FRAME_LINES(frame_lines), .LEN_ERR(len_err)
  );

  scv_video_sig #(.PW(8), .LW(4), .FW(9)) dut2 (
    .CLK(clk), .RESB(resb), .CE(ce), .DE(de), .VS(vs), .PIX(pix), .ARM(arm), .CONT(cont),
    .BUSY(d2_busy), .LINE_VALID(d2_lv), .LINE_CRC(d2_lcrc), .LINE_LEN(d2_len),
    .FRAME_VALID(d2_fv), .FRAME_CRC(d2_fcrc), .FRAME_LINES(d2_lines), .LEN_ERR(d2_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] sw_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mon();
    line_t el;
    frame_t ef;
    if (line_valid && frame_valid) both_n++;
    if (line_valid) begin
      lv_n++;
      checks++;
      assert (line_q.size() != 0) else begin
        errors++;
        $error("FAIL line_valid_unexpected observed pulse expected none");
      end
      if (line_q.size() != 0) begin
        el = line_q.pop_front();
        chk("line_crc", 32'(line_crc), 32'(el.crc));
        chk("line_len", 32'(line_len), 32'(el.len));
        chk("line_len_err", 32'(len_err), 32'(el.err));
      end
    end
    if (frame_valid) begin
      fv_n++;
      checks++;
      assert (frame_q.size() != 0) else begin
        errors++;
        $error("FAIL frame_valid_unexpected observed pulse expected none");
      end
      if (frame_q.size() != 0) begin
        ef = frame_q.pop_front();
        chk("frame_crc", 32'(frame_crc), 32'(ef.crc));
        chk("frame_lines", 32'(frame_lines), 32'(ef.lines));
        chk("frame_len_err", 32'(len_err), 32'(ef.err));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    mon();
  endtask

  task automatic pclk(input logic d, input logic v, input logic [7:0] p);
    de = d;
    vs = v;
    pix = p;
    ce = 1'b1;
    tick();
    ce = 1'b0;
    repeat (6) tick();
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic vs_pulse();
    pclk(1'b0, 1'b1, 8'h00);
    pclk(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_line(input int n, input logic err, input logic close,
                           inout logic [15:0] fcrc, output logic [15:0] lcrc);
    logic [7:0] b;
    lcrc = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      b = 8'h31 + 8'(i % 9);
      lcrc = sw_byte(lcrc, b);
      fcrc = sw_byte(fcrc, b);
      pclk(1'b1, 1'b0, b);
    end
    if (close) begin
      line_q.push_back('{lcrc, 10'(n), err});
      pclk(1'b0, 1'b0, 8'h00);
      pclk(1'b0, 1'b0, 8'h00);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_line_valid", 32'(line_valid), 0);
    chk("rst_line_crc", 32'(line_crc), 0);
    chk("rst_line_len", 32'(line_len), 0);
    chk("rst_frame_valid", 32'(frame_valid), 0);
    chk("rst_frame_crc", 32'(frame_crc), 0);
    chk("rst_frame_lines", 32'(frame_lines), 0);
    chk("rst_len_err", 32'(len_err), 0);
    chk("rst_d2_all", 32'({d2_busy, d2_lv, d2_fv, d2_err, d2_lcrc, d2_fcrc, d2_len, d2_lines}), 0);
  endtask

  initial begin
    logic [15:0] fc, lc;
    int fv0, lv0;
    resb = 1'b1; ce = 1'b0; de = 1'b0; vs = 1'b0; arm = 1'b0; cont = 1'b0; pix = 8'h00;
    #2 resb = 1'b0;
    repeat (3) tick();
    chk_reset_outputs();
    resb = 1'b1;
    tick();

    // one-shot, single "123456789" line
    arm_pulse();
    chk("armed_busy", 32'(busy), 1);
    vs_pulse();
    fc = 16'hFFFF;
    send_line(9, 1'b0, 1'b1, fc, lc);
    chk("check_value_29b1", 32'(lc), 32'h29B1);
    frame_q.push_back('{16'h29B1, 9'd1, 1'b0});
    vs_pulse();
    chk("t1_line_pulses", lv_n, 1);
    chk("t1_frame_pulses", fv_n, 1);
    chk("t1_done_busy", 32'(busy), 0);

    // three 9-pixel lines then an 8-pixel line
    arm_pulse();
    vs_pulse();
    fc = 16'hFFFF;
    repeat (3) send_line(9, 1'b0, 1'b1, fc, lc);
    send_line(8, 1'b1, 1'b1, fc, lc);
    frame_q.push_back('{fc, 9'd4, 1'b1});
    vs_pulse();
    chk("t2_busy", 32'(busy), 0);

    // continuous capture of three identical frames, ARM mid-capture ignored
    cont = 1'b1;
    fv0 = fv_n;
    arm_pulse();
    vs_pulse();
    for (int f = 0; f < 3; f++) begin
      fc = 16'hFFFF;
      send_line(5, 1'b0, 1'b1, fc, lc);
      if (f == 1) arm_pulse();
      send_line(5, 1'b0, 1'b1, fc, lc);
      frame_q.push_back('{fc, 9'd2, 1'b0});
      vs_pulse();
      chk("t3_busy_cont", 32'(busy), 1);
    end
    chk("t3_frame_pulses", fv_n - fv0, 3);
    cont = 1'b0;
    frame_q.push_back('{16'hFFFF, 9'd0, 1'b0});
    vs_pulse();
    chk("t3_empty_frame_busy", 32'(busy), 0);

    // DE held high across the frame boundary
    both_n = 0;
    arm_pulse();
    vs_pulse();
    fc = 16'hFFFF;
    send_line(4, 1'b0, 1'b1, fc, lc);
    send_line(3, 1'b0, 1'b0, fc, lc);
    line_q.push_back('{lc, 10'd3, 1'b1});
    frame_q.push_back('{fc, 9'd2, 1'b1});
    pclk(1'b1, 1'b1, 8'hAA);
    pclk(1'b1, 1'b0, 8'h55);
    pclk(1'b0, 1'b0, 8'h00);
    chk("t4_same_cycle", both_n, 1);
    chk("t4_busy", 32'(busy), 0);

    // pixel counter saturation on the LW=4 instance
    arm_pulse();
    vs_pulse();
    fc = 16'hFFFF;
    send_line(20, 1'b0, 1'b1, fc, lc);
    chk("t5_sat_len", 32'(d2_len), 15);
    frame_q.push_back('{fc, 9'd1, 1'b0});
    vs_pulse();

    // reset in the middle of a line
    arm_pulse();
    vs_pulse();
    fc = 16'hFFFF;
    send_line(4, 1'b0, 1'b0, fc, lc);
    resb = 1'b0;
    de = 1'b0;
    repeat (3) tick();
    chk_reset_outputs();
    resb = 1'b1;
    lv0 = lv_n;
    fv0 = fv_n;
    vs_pulse();
    repeat (3) pclk(1'b1, 1'b0, 8'h11);
    pclk(1'b0, 1'b0, 8'h00);
    vs_pulse();
    arm_pulse();
    repeat (3) pclk(1'b1, 1'b0, 8'h22);
    pclk(1'b0, 1'b0, 8'h00);
    chk("t6_no_line_pulse", lv_n - lv0, 0);
    chk("t6_no_frame_pulse", fv_n - fv0, 0);
    vs_pulse();
    fc = 16'hFFFF;
    send_line(9, 1'b0, 1'b1, fc, lc);
    frame_q.push_back('{fc, 9'd1, 1'b0});
    vs_pulse();
    chk("t6_done_busy", 32'(busy), 0);

    chk("line_queue_drained", line_q.size(), 0);
    chk("frame_queue_drained", frame_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
